// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester-side handshakes and memory-side signals for mem_port_arbiter.
// The arbiter connects through the slave modport; requesters/memory use master.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_done;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_done;
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_wr;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;
  logic [1:0]        state_out;

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_done, d_gnt, d_done, rdata, mem_addr, mem_wdata, mem_wr,
           busy, state_out
  );

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_done, d_gnt, d_done, rdata, mem_addr, mem_wdata, mem_wr,
           busy, state_out
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Fetch vs load/store arbiter for a single-port memory with fixed access latency.
// Define ARB_RR_EN for round-robin tie-breaking; default is fixed data > fetch priority.
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 2
) (
  input logic                clock,
  input logic                reset,
  mem_port_arbiter_if.slave  bus
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  localparam int CNT_W = ($clog2(WAIT_CYCLES + 1) > 1) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic              lat_we;
  logic              owner;      // 1 = data requester, 0 = fetch
  logic [DATA_W-1:0] rdata_q;
  logic              any_req;
  logic              d_wins;

  assign any_req = bus.if_req | bus.d_req;

`ifdef ARB_RR_EN
  logic last_owner;

  // Ties go to whoever was not granted last; resets to fetch so the first tie goes to data.
  assign d_wins = bus.d_req & (~bus.if_req | ~last_owner);

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      last_owner <= 1'b0;
    else if (state == IDLE && any_req)
      last_owner <= d_wins;
  end
`else
  assign d_wins = bus.d_req;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_we    <= 1'b0;
      owner     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            owner     <= d_wins;
            lat_addr  <= d_wins ? bus.d_addr : bus.if_addr;
            lat_wdata <= d_wins ? bus.d_wdata : '0;
            lat_we    <= d_wins & bus.d_we;
            cnt       <= CNT_LOAD;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt == '0) begin
            rdata_q <= bus.mem_rdata;
            state   <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.if_gnt    = (state == IDLE) & bus.if_req & ~d_wins;
  assign bus.d_gnt     = (state == IDLE) & d_wins;
  assign bus.if_done   = (state == RESP) & ~owner;
  assign bus.d_done    = (state == RESP) & owner;
  assign bus.rdata     = rdata_q;
  assign bus.mem_addr  = lat_addr;
  assign bus.mem_wdata = lat_wdata;
  // Write strobe is decoded from state so an asynchronous reset drops it immediately.
  assign bus.mem_wr    = (state == ACCESS) & lat_we;
  assign bus.busy      = (state != IDLE);
  assign bus.state_out = state;
endmodule
